// File: rtl/dmem_arbiter_rv32i_pkg.sv
// dmem_arbiter_rv32i_pkg: shared encodings for storetype, access owner and sequencer state
package dmem_arbiter_rv32i_pkg;
  typedef enum logic [1:0] {ST_BYTE = 2'b00, ST_HALF = 2'b01, ST_WORD = 2'b10, ST_BAD = 2'b11} st_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} own_e;
  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select (idle_i/cpu_req_i/dbg_req_i/last_i/burst_i in; any_o/win_o/burst_o out) with DBG burst counter next state
module dmem_arb_pick
  import dmem_arbiter_rv32i_pkg::*;
#(
  parameter int ARB_MODE      = 0,
  parameter int MAX_DBG_BURST = 4
) (
  input  logic       idle_i,
  input  logic       cpu_req_i,
  input  logic       dbg_req_i,
  input  own_e       last_i,
  input  logic [3:0] burst_i,
  output logic       any_o,
  output own_e       win_o,
  output logic [3:0] burst_o
);
  logic rr_dbg, fp_dbg;
  always_comb begin
    any_o   = idle_i && (cpu_req_i || dbg_req_i);
    rr_dbg  = dbg_req_i && (!cpu_req_i || last_i == OWN_CPU);
    fp_dbg  = dbg_req_i && !(cpu_req_i && burst_i == 4'(MAX_DBG_BURST));
    win_o   = ((ARB_MODE == 1) ? fp_dbg : rr_dbg) ? OWN_DBG : OWN_CPU;
    burst_o = (!cpu_req_i || (any_o && win_o == OWN_CPU)) ? 4'd0 :
              (any_o && burst_i != 4'hf) ? burst_i + 4'd1 : burst_i;
  end
endmodule

// File: rtl/dmem_arbiter_rv32i.sv
// dmem_arbiter_rv32i: CPU/DBG data-memory arbiter (req/we/storetype/addr/wdata in, gnt/rvalid/rdata/err out per side; cu_store/cu_storetype/dmem_addr/rs2 out, dmem_out in)
module dmem_arbiter_rv32i
  import dmem_arbiter_rv32i_pkg::*;
#(
  parameter int ARB_MODE      = 0,
  parameter int MAX_DBG_BURST = 4,
  parameter int MEM_BYTES     = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_storetype,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [1:0]  dbg_storetype,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        cu_store,
  output logic [1:0]  cu_storetype,
  output logic [31:0] dmem_addr,
  output logic [31:0] rs2,
  input  logic [31:0] dmem_out
);
  state_e      state_q;
  own_e        own_q, last_q, win;
  logic        we_q, err_q, any, acc, we_w, err_w;
  logic [1:0]  st_q, st_w;
  logic [31:0] addr_q, wdata_q, addr_w, wdata_w, cpu_rdata_q, dbg_rdata_q;
  logic        cpu_rvalid_q, dbg_rvalid_q, cpu_err_q, dbg_err_q;
  logic [3:0]  burst_q, burst_d;
  dmem_arb_pick #(.ARB_MODE(ARB_MODE), .MAX_DBG_BURST(MAX_DBG_BURST)) u_pick (
    .idle_i   (state_q == S_IDLE),
    .cpu_req_i(cpu_req),
    .dbg_req_i(dbg_req),
    .last_i   (last_q),
    .burst_i  (burst_q),
    .any_o    (any),
    .win_o    (win),
    .burst_o  (burst_d)
  );
  always_comb begin
    acc     = state_q == S_ACCESS;
    we_w    = win == OWN_DBG ? dbg_we : cpu_we;
    st_w    = win == OWN_DBG ? dbg_storetype : cpu_storetype;
    addr_w  = win == OWN_DBG ? dbg_addr : cpu_addr;
    wdata_w = win == OWN_DBG ? dbg_wdata : cpu_wdata;
    err_w   = addr_w >= 32'(MEM_BYTES) || st_w == ST_BAD ||
              (st_w == ST_HALF && addr_w[0]) || (st_w == ST_WORD && addr_w[1:0] != 2'b00);
  end
  assign cpu_gnt      = reset_n && any && win == OWN_CPU;
  assign dbg_gnt      = reset_n && any && win == OWN_DBG;
  // reset_n gates the write directly so a store caught by reset never lands
  assign cu_store     = reset_n && acc && we_q && !err_q;
  assign cu_storetype = acc ? st_q : 2'b00;
  assign dmem_addr    = acc ? addr_q : 32'd0;
  assign rs2          = acc ? wdata_q : 32'd0;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_err      = cpu_err_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign dbg_err      = dbg_err_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      own_q        <= OWN_CPU;
      last_q       <= OWN_DBG;
      burst_q      <= 4'd0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      st_q         <= 2'b00;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cpu_rdata_q  <= 32'd0;
      dbg_rdata_q  <= 32'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      dbg_err_q    <= 1'b0;
    end else begin
      burst_q      <= burst_d;
      cpu_rvalid_q <= acc && own_q == OWN_CPU;
      dbg_rvalid_q <= acc && own_q == OWN_DBG;
      cpu_err_q    <= acc && own_q == OWN_CPU && err_q;
      dbg_err_q    <= acc && own_q == OWN_DBG && err_q;
      if (acc) begin
        state_q <= S_IDLE;
        if (own_q == OWN_CPU) cpu_rdata_q <= err_q ? 32'd0 : dmem_out;
        else dbg_rdata_q <= err_q ? 32'd0 : dmem_out;
      end else if (any) begin
        state_q <= S_ACCESS;
        own_q   <= win;
        last_q  <= win;
        we_q    <= we_w;
        st_q    <= st_w;
        addr_q  <= addr_w;
        wdata_q <= wdata_w;
        err_q   <= err_w;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter_rv32i.sv
// tb_dmem_arbiter_rv32i: vector table, arbitration sequences and randomized reference-model check of dmem_arbiter_rv32i
module tb_dmem_arbiter_rv32i;
  logic clk, reset_n;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [1:0] cpu_storetype, dbg_storetype, cu_storetype;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, cpu_rdata, dbg_rdata, dmem_addr, rs2, dmem_out;
  logic cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err, cu_store;
  logic f_cpu_req, f_dbg_req, f_cpu_gnt, f_dbg_gnt, f_cpu_rv, f_dbg_rv, f_cpu_err, f_dbg_err, f_store;
  logic [1:0] f_st;
  logic [31:0] f_cpu_rd, f_dbg_rd, f_addr, f_rs2;
  logic [31:0] mem [256];
  logic [7:0] rmem [1024];
  int tests = 0, fails = 0;

  dmem_arbiter_rv32i #(.ARB_MODE(0)) dut (
    .clock(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_storetype(cpu_storetype), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_storetype(dbg_storetype), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .cu_store(cu_store), .cu_storetype(cu_storetype), .dmem_addr(dmem_addr), .rs2(rs2), .dmem_out(dmem_out)
  );

  dmem_arbiter_rv32i #(.ARB_MODE(1), .MAX_DBG_BURST(4)) u_fp (
    .clock(clk), .reset_n(reset_n),
    .cpu_req(f_cpu_req), .cpu_we(1'b0), .cpu_storetype(2'b10), .cpu_addr(32'd0), .cpu_wdata(32'd0),
    .cpu_gnt(f_cpu_gnt), .cpu_rvalid(f_cpu_rv), .cpu_rdata(f_cpu_rd), .cpu_err(f_cpu_err),
    .dbg_req(f_dbg_req), .dbg_we(1'b0), .dbg_storetype(2'b10), .dbg_addr(32'd4), .dbg_wdata(32'd0),
    .dbg_gnt(f_dbg_gnt), .dbg_rvalid(f_dbg_rv), .dbg_rdata(f_dbg_rd), .dbg_err(f_dbg_err),
    .cu_store(f_store), .cu_storetype(f_st), .dmem_addr(f_addr), .rs2(f_rs2), .dmem_out(32'd0)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // data memory: byte-enabled write on falling edge, asynchronous read
  assign dmem_out = mem[dmem_addr[9:2]];
  always @(negedge clk)
    if (cu_store)
      case (cu_storetype)
        2'b00:   mem[dmem_addr[9:2]][{dmem_addr[1:0], 3'b000} +: 8] <= rs2[7:0];
        2'b01:   mem[dmem_addr[9:2]][{dmem_addr[1], 4'b0000} +: 16] <= rs2[15:0];
        default: mem[dmem_addr[9:2]] <= rs2;
      endcase

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] st);
    return a >= 32'd1024 || st == 2'b11 || (st == 2'b01 && a[0]) || (st == 2'b10 && a[1:0] != 2'b00);
  endfunction

  typedef struct {
    bit dbg; bit we; logic [1:0] st; logic [31:0] addr; logic [31:0] wdata;
    bit err; bit chk_rd; logic [31:0] rdata;
  } vec_t;

  task automatic apply_reset();
    cpu_req = 0; dbg_req = 0; f_cpu_req = 0; f_dbg_req = 0;
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w = 0;
    @(posedge clk); #1;
    if (v.dbg) begin
      dbg_req = 1; dbg_we = v.we; dbg_storetype = v.st; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_storetype = v.st; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clk);
    while (!(v.dbg ? dbg_gnt : cpu_gnt) && w < 20) begin w++; @(negedge clk); end
    chk($sformatf("v%0d_gnt_wait", idx), w, 0);
    @(posedge clk); #1 cpu_req = 0; dbg_req = 0;
    @(negedge clk);
    chk($sformatf("v%0d_cu_store", idx), cu_store, v.we && !v.err);
    chk($sformatf("v%0d_dmem_addr", idx), dmem_addr, v.addr);
    chk($sformatf("v%0d_cu_st", idx), cu_storetype, v.st);
    chk($sformatf("v%0d_rs2", idx), rs2, v.wdata);
    @(negedge clk);
    chk($sformatf("v%0d_rvalid", idx), v.dbg ? dbg_rvalid : cpu_rvalid, 1);
    chk($sformatf("v%0d_other_rvalid", idx), v.dbg ? cpu_rvalid : dbg_rvalid, 0);
    chk($sformatf("v%0d_err", idx), v.dbg ? dbg_err : cpu_err, v.err);
    if (v.chk_rd) chk($sformatf("v%0d_rdata", idx), v.dbg ? dbg_rdata : cpu_rdata, v.rdata);
  endtask

  initial begin
    vec_t vt [8];
    bit pend [2], pwe [2];
    logic [1:0] pst [2];
    logic [31:0] paddr [2], pwd [2];
    int gcnt, fcnt, lg, gcyc, c, rown, last;
    bit rerr, rld, win, has;
    logic [31:0] rrd;

    vt[0] = '{0, 1, 2'b10, 32'h010, 32'hDEADBEEF, 0, 0, 0};
    vt[1] = '{0, 0, 2'b10, 32'h010, 32'h0, 0, 1, 32'hDEADBEEF};
    vt[2] = '{1, 1, 2'b01, 32'h013, 32'h5555, 1, 1, 32'h0};
    vt[3] = '{0, 1, 2'b10, 32'h400, 32'h11111111, 1, 1, 32'h0};
    vt[4] = '{0, 0, 2'b11, 32'h010, 32'h0, 1, 1, 32'h0};
    vt[5] = '{0, 0, 2'b10, 32'h010, 32'h0, 0, 1, 32'hDEADBEEF};
    vt[6] = '{1, 1, 2'b00, 32'h021, 32'h000000AB, 0, 0, 0};
    vt[7] = '{0, 0, 2'b10, 32'h020, 32'h0, 0, 1, 32'h0000AB00};

    foreach (mem[i]) mem[i] = 32'd0;
    cpu_we = 0; cpu_storetype = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_we = 0; dbg_storetype = 0; dbg_addr = 0; dbg_wdata = 0;
    cpu_req = 0; dbg_req = 0; f_cpu_req = 0; f_dbg_req = 0; reset_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err, cu_store}, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 0);
    @(posedge clk); #1 reset_n = 1;

    // reset during the ACCESS cycle of a store
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_storetype = 2'b10; cpu_addr = 32'h020; cpu_wdata = 32'h12345678;
    @(negedge clk); chk("rstacc_gnt", cpu_gnt, 1);
    @(posedge clk); #1 cpu_req = 0; reset_n = 0;
    @(negedge clk); chk("rstacc_cu_store", cu_store, 0);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("rstacc_idle_outs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err, cu_store, cu_storetype}, 0);
    chk("rstacc_idle_addr", dmem_addr | rs2 | cpu_rdata | dbg_rdata, 0);
    chk("rstacc_mem", mem[8], 0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // ARB_MODE=0 alternation and ARB_MODE=1 burst guard, both with requests held
    apply_reset();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_storetype = 2'b10; cpu_addr = 32'h010;
    dbg_req = 1; dbg_we = 0; dbg_storetype = 2'b10; dbg_addr = 32'h020;
    f_cpu_req = 1; f_dbg_req = 1;
    gcnt = 0; fcnt = 0; lg = -10;
    for (int cyc = 0; cyc < 40 && (gcnt < 8 || fcnt < 10); cyc++) begin
      @(negedge clk);
      if (cpu_gnt && dbg_gnt) chk("rr_both_gnt", 1, 0);
      if ((cpu_gnt || dbg_gnt) && gcnt < 8) begin
        chk($sformatf("rr_owner%0d", gcnt), dbg_gnt, gcnt % 2);
        chk($sformatf("rr_gap%0d", gcnt), cyc - lg >= 2, 1);
        lg = cyc; gcnt++;
      end
      if ((f_cpu_gnt || f_dbg_gnt) && fcnt < 10) begin
        chk($sformatf("fp_owner%0d", fcnt), f_cpu_gnt, fcnt % 5 == 4);
        fcnt++;
      end
      @(posedge clk); #1;
    end
    chk("rr_grant_count", gcnt, 8);
    chk("fp_grant_count", fcnt, 10);
    cpu_req = 0; dbg_req = 0; f_cpu_req = 0; f_dbg_req = 0;
    repeat (3) @(posedge clk);

    // randomized traffic against a byte-array reference model
    apply_reset();
    for (int i = 0; i < 256; i++) for (int k = 0; k < 4; k++) rmem[4*i+k] = mem[i][8*k +: 8];
    pend[0] = 0; pend[1] = 0; gcyc = -10; last = 1; rown = 0; rerr = 0; rld = 0; rrd = 0;
    for (c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++)
        if (!pend[s] && $urandom % 3 == 0) begin
          pend[s] = 1;
          pwe[s] = 1'($urandom);
          pst[s] = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
          paddr[s] = ($urandom % 10 == 0) ? 32'h3F0 + ($urandom % 32) : $urandom % 256;
          if ($urandom % 4 != 0) paddr[s] = pst[s] == 2'b10 ? paddr[s] & ~32'd3 : pst[s] == 2'b01 ? paddr[s] & ~32'd1 : paddr[s];
          pwd[s] = $urandom;
        end
      cpu_req = pend[0]; cpu_we = pwe[0]; cpu_storetype = pst[0]; cpu_addr = paddr[0]; cpu_wdata = pwd[0];
      dbg_req = pend[1]; dbg_we = pwe[1]; dbg_storetype = pst[1]; dbg_addr = paddr[1]; dbg_wdata = pwd[1];
      @(negedge clk);
      if (c == gcyc + 2) begin
        chk("rnd_rvalid", {dbg_rvalid, cpu_rvalid}, rown ? 2'b10 : 2'b01);
        chk("rnd_err", rown ? dbg_err : cpu_err, rerr);
        if (rld || rerr) chk("rnd_rdata", rown ? dbg_rdata : cpu_rdata, rrd);
      end else chk("rnd_no_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
      has = (c != gcyc + 1) && (pend[0] || pend[1]);
      win = pend[0] && pend[1] ? (last == 0) : pend[1];
      chk("rnd_cpu_gnt", cpu_gnt, has && !win);
      chk("rnd_dbg_gnt", dbg_gnt, has && win);
      if (has) begin
        rown = win; last = win; gcyc = c; pend[win] = 0;
        rerr = ref_err(paddr[win], pst[win]); rld = !pwe[win]; rrd = 0;
        if (!rerr && rld)
          for (int k = 0; k < 4; k++) rrd[8*k +: 8] = rmem[(paddr[win] & ~32'd3) + k];
        if (!rerr && !rld)
          for (int k = 0; k < (pst[win] == 2'b00 ? 1 : pst[win] == 2'b01 ? 2 : 4); k++)
            rmem[paddr[win] + k] = pwd[win][8*k +: 8];
      end
    end
    cpu_req = 0; dbg_req = 0;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
